// File: rtl/counter_pkg.sv
// Shared types and constants for the parametrised up/down counter core.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and boundary-event logic for the up/down counter.
module updown_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MOD_MAX = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             sel,
    input  cnt_mode_e        mode,
    output logic [WIDTH-1:0] next,
    output logic             evt
);

    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MOD_MAX);
    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO_W = '0;

    logic [WIDTH:0] data_w;
    logic [WIDTH:0] next_w;

    assign data_w = {1'b0, data};

    // Work one bit wider than the count so the MOD_MAX compare cannot alias.
    always_comb begin
        next_w = data_w;
        evt    = 1'b0;
        if (sel == DIR_UP) begin
            if (data_w >= MAX_W) begin
                evt    = 1'b1;
                next_w = (mode == MODE_SAT) ? MAX_W : ZERO_W;
            end else begin
                next_w = data_w + ONE_W;
            end
        end else begin
            if (data_w == ZERO_W) begin
                evt    = 1'b1;
                next_w = (mode == MODE_SAT) ? ZERO_W : MAX_W;
            end else begin
                next_w = data_w - ONE_W;
            end
        end
    end

    assign next = next_w[WIDTH-1:0];

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: load with clamp, wrap/saturate, event pulse and sticky overflow.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MOD_MAX = 2**WIDTH - 1,
    parameter int RST_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sel_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] data_o,
    output logic             evt_o,
    output logic             ovf_o
);

    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MOD_MAX);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] data_q;
    logic             evt_q;
    logic             ovf_q;

    logic [WIDTH-1:0] cnt_next;
    logic             cnt_evt;
    logic [WIDTH-1:0] load_clamped;
    logic             count_evt;

    updown_counter_next #(
        .WIDTH   (WIDTH),
        .MOD_MAX (MOD_MAX)
    ) u_next (
        .data (data_q),
        .sel  (sel_i),
        .mode (cnt_mode_e'(mode_i)),
        .next (cnt_next),
        .evt  (cnt_evt)
    );

    // Out-of-range loads saturate to MOD_MAX rather than dropping high bits.
    assign load_clamped = ({1'b0, load_val_i} > MAX_W) ? MAX_W[WIDTH-1:0] : load_val_i;

    assign count_evt = en_i & ~load_i & cnt_evt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= RST_Q;
            evt_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (load_i) begin
                data_q <= load_clamped;
            end else if (en_i) begin
                data_q <= cnt_next;
            end
            evt_q <= count_evt;
            // A boundary event on the same edge as a clear keeps the flag set.
            if (count_evt) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign data_o = data_q;
    assign evt_o  = evt_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param (WIDTH=4, MOD_MAX=9, RST_VAL=0).
module tb_updown_counter_param;

    localparam int WIDTH   = 4;
    localparam int MOD_MAX = 9;
    localparam int RST_VAL = 0;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             en_i = 1'b0;
    logic             sel_i = 1'b0;
    logic             mode_i = 1'b0;
    logic             load_i = 1'b0;
    logic [WIDTH-1:0] load_val_i = '0;
    logic             clr_ovf_i = 1'b0;
    logic [WIDTH-1:0] data_o;
    logic             evt_o;
    logic             ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_data = RST_VAL;
    int m_evt  = 0;
    int m_ovf  = 0;

    updown_counter_param #(
        .WIDTH   (WIDTH),
        .MOD_MAX (MOD_MAX),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .sel_i      (sel_i),
        .mode_i     (mode_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .clr_ovf_i  (clr_ovf_i),
        .data_o     (data_o),
        .evt_o      (evt_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the spec's rules applied to plain integers.
    task automatic model_edge(input int rst, input int en, input int sel, input int mode,
                              input int load, input int lv, input int clr);
        int at_bound;
        if (rst == 0) begin
            m_data = RST_VAL; m_evt = 0; m_ovf = 0;
        end else if (load != 0) begin
            m_data = (lv > MOD_MAX) ? MOD_MAX : lv;
            m_evt  = 0;
            if (clr != 0) m_ovf = 0;
        end else if (en != 0) begin
            at_bound = (sel != 0) ? (m_data == 0) : (m_data == MOD_MAX);
            if (at_bound == 0)      m_data = (sel != 0) ? m_data - 1 : m_data + 1;
            else if (mode == 0)     m_data = (sel != 0) ? MOD_MAX : 0;
            m_evt = at_bound;
            if (at_bound != 0)      m_ovf = 1;
            else if (clr != 0)      m_ovf = 0;
        end else begin
            m_evt = 0;
            if (clr != 0) m_ovf = 0;
        end
    endtask

    task automatic step(input string tag, input int rst, input int en, input int sel,
                        input int mode, input int load, input int lv, input int clr);
        rst_ni     = (rst != 0);
        en_i       = (en != 0);
        sel_i      = (sel != 0);
        mode_i     = (mode != 0);
        load_i     = (load != 0);
        load_val_i = WIDTH'(lv);
        clr_ovf_i  = (clr != 0);
        @(posedge clk_i);
        #1;
        model_edge(rst, en, sel, mode, load, lv, clr);
        check({tag, "_data"}, int'(data_o), m_data);
        check({tag, "_evt"},  int'(evt_o),  m_evt);
        check({tag, "_ovf"},  int'(ovf_o),  m_ovf);
    endtask

    initial begin
        int evt_cnt;
        int exp_d;

        // 1: reset then wrap upward
        for (int i = 0; i < 3; i++) step("rst", 0, 1, 0, 0, 1, 5, 0);
        check("rst_data_const", int'(data_o), 0);
        check("rst_evt_const",  int'(evt_o),  0);
        check("rst_ovf_const",  int'(ovf_o),  0);
        evt_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            step("s1", 1, 1, 0, 0, 0, 0, 0);
            exp_d = (i + 1) % 10;
            check("s1_seq", int'(data_o), exp_d);
            check("s1_evt_seq", int'(evt_o), (i == 9) ? 1 : 0);
            evt_cnt += int'(evt_o);
        end
        check("s1_evt_count", evt_cnt, 1);
        check("s1_ovf_after", int'(ovf_o), 1);

        // 2: load 3, count down through wrap, clear ovf
        step("s2_load", 1, 0, 0, 0, 1, 3, 0);
        check("s2_load_const", int'(data_o), 3);
        for (int i = 0; i < 4; i++) begin
            step("s2", 1, 1, 1, 0, 0, 0, 0);
            check("s2_seq", int'(data_o), (i == 3) ? 9 : 2 - i);
            check("s2_evt_seq", int'(evt_o), (i == 3) ? 1 : 0);
        end
        step("s2_clr", 1, 0, 1, 0, 0, 0, 1);
        check("s2_ovf_cleared", int'(ovf_o), 0);

        // 3: saturate upward from 7, then step down
        step("s3_load", 1, 0, 0, 1, 1, 7, 0);
        for (int i = 0; i < 5; i++) begin
            step("s3", 1, 1, 0, 1, 0, 0, 0);
            check("s3_seq", int'(data_o), (i == 0) ? 8 : 9);
            check("s3_evt_seq", int'(evt_o), (i >= 2) ? 1 : 0);
        end
        step("s3_down", 1, 1, 1, 1, 0, 0, 0);
        check("s3_down_data", int'(data_o), 8);
        check("s3_down_evt",  int'(evt_o),  0);

        // 4: clamped load, load beats enable, set beats clear
        step("s4_clamp", 1, 0, 0, 0, 1, 14, 0);
        check("s4_clamp_const", int'(data_o), 9);
        step("s4_ld_en", 1, 1, 0, 0, 1, 2, 0);
        check("s4_ld_en_const", int'(data_o), 2);
        step("s4_clr", 1, 0, 0, 0, 0, 0, 1);
        check("s4_ovf_pre", int'(ovf_o), 0);
        step("s4_ld9", 1, 0, 0, 0, 1, 9, 0);
        step("s4_wrapclr", 1, 1, 0, 0, 0, 0, 1);
        check("s4_wrap_data", int'(data_o), 0);
        check("s4_set_wins", int'(ovf_o), 1);

        // 5: reset overrides an active load while counting
        step("s5_ld6", 1, 0, 0, 0, 1, 6, 0);
        step("s5_rst", 0, 1, 0, 0, 1, 3, 0);
        check("s5_rst_data", int'(data_o), 0);
        check("s5_rst_evt",  int'(evt_o),  0);
        check("s5_rst_ovf",  int'(ovf_o),  0);
        step("s5_resume", 1, 1, 0, 0, 0, 0, 0);
        check("s5_resume_data", int'(data_o), 1);

        // 6: random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step("rnd",
                 ($urandom_range(63) == 0) ? 0 : 1,
                 ($urandom_range(3) != 0) ? 1 : 0,
                 int'($urandom_range(1)),
                 int'($urandom_range(1)),
                 ($urandom_range(7) == 0) ? 1 : 0,
                 int'($urandom_range(15)),
                 ($urandom_range(15) == 0) ? 1 : 0);
            check("rnd_range", (int'(data_o) <= MOD_MAX) ? 1 : 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter, the successor to the fixed 4-bit select-driven counter. It adds configurable width and modulus, parallel load, count enable, and a runtime wrap/saturate mode. It also provides a registered terminal-event pulse and a sticky overflow flag. It sits behind the synthesis wrapper as the counting core for timers and dividers.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MOD_MAX, 2**WIDTH-1, highest count value; counting range is 0..MOD_MAX (must be < 2**WIDTH)
RST_VAL, 0, value of data_o after reset (must be <= MOD_MAX)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  synchronous active-low reset
en_i  in  1  count enable
sel_i  in  1  direction: 0 = up, 1 = down
mode_i  in  1  cnt_mode_e: 0 = MODE_WRAP, 1 = MODE_SAT
load_i  in  1  parallel load strobe
load_val_i  in  WIDTH  value to load
clr_ovf_i  in  1  clears sticky overflow flag
data_o  out  WIDTH  current count
evt_o  out  1  one-cycle pulse: last update hit a boundary
ovf_o  out  1  sticky boundary-event flag

Behaviour:
- Reset: one clock is one step: clk_i and rst_ni only. Reset is synchronous, active-low. rst_ni=0 at a rising edge gives data_o=RST_VAL, evt_o=0, ovf_o=0. Reset overrides every other input, including mid-count and mid-load.
- Priority per edge: reset > load > count > hold.
- Load (load_i=1):
  - data_o <= min(load_val_i, MOD_MAX).
  - Load ignores en_i and sel_i.
  - evt_o <= 0. ovf_o is unchanged, apart from clr_ovf_i.
- Count (load_i=0, en_i=1), up direction (sel_i=0):
  - If data_o < MOD_MAX, then data_o+1.
  - If data_o == MOD_MAX: WRAP gives 0, SAT holds MOD_MAX. Either case is a boundary event.
- Count, down direction (sel_i=1):
  - If data_o > 0, then data_o-1.
  - If data_o == 0: WRAP gives MOD_MAX, SAT holds 0. Either case is a boundary event.
- Hold: en_i=0 and load_i=0 keeps data_o; evt_o <= 0.
- evt_o:
  - Registered, 1-cycle latency. It is high in the cycle after the edge where the boundary event occurred, coincident with the wrapped or held value on data_o.
  - In SAT mode with en_i held at a boundary, evt_o stays high every cycle. The event recurs each edge.
- ovf_o:
  - Set on any boundary event.
  - Cleared by clr_ovf_i=1.
  - Simultaneous set and clear: set wins.
  - Otherwise holds.
- Direction or mode changes take effect at the next edge. No pipeline, no illegal states.
- Arithmetic: next-value logic is computed in WIDTH+1 bits, then compared against MOD_MAX. The result never leaves 0..MOD_MAX, so non-power-of-two MOD_MAX works without aliasing.
- Load values above MOD_MAX are clamped, not truncated.

Decomposition:
- Shared package counter_pkg contains:
  - typedef enum logic {MODE_WRAP, MODE_SAT} cnt_mode_e
  - localparam direction constants DIR_UP=1'b0 and DIR_DOWN=1'b1
- One combinational sub-module, updown_counter_next. It computes the next count and the boundary-event flag from (data, sel, mode, MOD_MAX).
- The top holds the registers, load, clamp and the flags.

Test Plan:
All scenarios use WIDTH=4, MOD_MAX=9, RST_VAL=0.
1. Reset 3 cycles, then en=1, sel=0, WRAP for 12 cycles -> data 0,1..9,0,1; evt_o high exactly once, in the cycle data_o shows 0 after 9; ovf_o=1 thereafter.
2. Load 3, then sel=1, WRAP, en=1 -> 3,2,1,0,9; evt_o pulses with 9; clr_ovf_i=1 for one cycle -> ovf_o=0.
3. SAT, up from 7, 5 cycles -> 8,9,9,9,9; evt_o high on each of the three 9-hold cycles; switch to sel=1 -> 8, evt_o=0.
4. load_i=1 with load_val_i=14 -> data_o=9. load_i and en_i together -> load wins. clr_ovf_i coinciding with a wrap -> ovf_o=1.
5. rst_ni=0 asserted while counting at 6 with load_i=1 -> next edge data_o=0, evt_o=0, ovf_o=0. Release -> counting resumes from 0.
6. Random en/sel/mode/load for 2000 cycles against a reference model -> data_o always <= 9, exact match on every cycle.
